// File: rtl/async_mem_preloader.sv
// Byte-stream to word-memory preload engine: packs bytes into little- or big-endian words
// and writes them from BASE_ADDR upward. Define PRELOADER_CKSUM_EN to add the cksum output.
module async_mem_preloader #(
    parameter int ADDR_W         = 12,
    parameter int BYTES_PER_WORD = 4,
    parameter int BASE_ADDR      = 0,
    parameter int BIG_ENDIAN     = 0
) (
    input  logic                        clk,
    input  logic                        rst_async,
    input  logic                        start,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    input  logic                        byte_last,
    output logic                        byte_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [8*BYTES_PER_WORD-1:0] mem_wdata,
    output logic [BYTES_PER_WORD-1:0]   mem_wmask,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
`ifdef PRELOADER_CKSUM_EN
    output logic [31:0]                 cksum,
`endif
    output logic [ADDR_W:0]             word_count
);

    localparam int                LANE_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state, state_nxt;
    logic [LANE_W-1:0]           lane;
    logic [LANE_W-1:0]           lane_sel;
    logic [8*BYTES_PER_WORD-1:0] pack;
    logic [BYTES_PER_WORD-1:0]   mask;
    logic                        last_seen;
    logic                        accept;
    logic                        start_ok;
    logic                        word_end;
    logic                        at_top;

    assign accept   = byte_valid && byte_ready;
    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign word_end = accept && (state == S_COLLECT) && (lane == LAST_LANE || byte_last);
    assign at_top   = (mem_addr == '1);
    assign lane_sel = (BIG_ENDIAN != 0) ? LAST_LANE - lane : lane;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start_ok) state_nxt = S_COLLECT;
            S_COLLECT:      if (word_end) state_nxt = S_WRITE;
            S_WRITE: begin
                if (last_seen)   state_nxt = S_DONE;
                else if (at_top) state_nxt = S_DRAIN;
                else             state_nxt = S_COLLECT;
            end
            S_DRAIN:        if (accept && byte_last) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == S_COLLECT) || (state == S_DRAIN);
        mem_we     = (state == S_WRITE);
        busy       = (state == S_COLLECT) || (state == S_WRITE) || (state == S_DRAIN);
        done       = (state == S_DONE);
        mem_wdata  = mem_we ? pack : '0;
        mem_wmask  = mem_we ? mask : '0;
    end

    // NOTE: the packing register is a handful of flops, not a memory, so it is reset like any other state.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            lane       <= '0;
            pack       <= '0;
            mask       <= '0;
            last_seen  <= 1'b0;
            mem_addr   <= BASE;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (start_ok) begin
                lane       <= '0;
                pack       <= '0;
                mask       <= '0;
                last_seen  <= 1'b0;
                mem_addr   <= BASE;
                word_count <= '0;
                overflow   <= 1'b0;
            end else if (state == S_COLLECT && accept) begin
                pack[lane_sel*8 +: 8] <= byte_data;
                mask[lane_sel]        <= 1'b1;
                last_seen             <= byte_last;
                if (!word_end) lane <= lane + 1'b1;
            end else if (state == S_WRITE) begin
                word_count <= word_count + 1'b1;
                if (!last_seen) begin
                    if (at_top) begin
                        overflow <= 1'b1;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                        lane     <= '0;
                        pack     <= '0;
                        mask     <= '0;
                    end
                end
            end
        end
    end

`ifdef PRELOADER_CKSUM_EN
    // Sums every accepted byte, drained ones included, so the image can be verified end to end.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            cksum <= '0;
        end else if (start_ok) begin
            cksum <= '0;
        end else if (accept) begin
            cksum <= cksum + {24'd0, byte_data};
        end
    end
`endif

endmodule

// File: tb/tb_async_mem_preloader.sv
// Self-checking bench: three loader instances (default, big-endian, tiny overflowing memory)
// compared against a word-level reference model of the packing and overflow rules.
module tb_async_mem_preloader;

    typedef logic [7:0] byteq_t[$];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    typedef wr_t wrq_t[$];

    typedef struct {
        int          d;
        int          n;
        logic [7:0]  b0;
        logic [7:0]  step;
        int          exp_wc;
        logic        exp_ovf;
        logic [11:0] exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_mask;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st[3];
    logic       bv[3];
    logic       bl[3];
    logic [7:0] bd[3];

    logic        rdy[3], we[3], busy_o[3], done_o[3], ovf_o[3];
    logic [31:0] wd[3];
    logic [3:0]  wm[3];
    logic [11:0] addr0, addr1;
    logic [1:0]  addr2;
    logic [12:0] wc0, wc1;
    logic [2:0]  wc2;
    logic [11:0] addr_m[3];
    logic [12:0] wc_m[3];
`ifdef PRELOADER_CKSUM_EN
    logic [31:0] ck[3];
`endif

    int  n_tests = 0;
    int  n_fail  = 0;
    int  sel     = 0;
    wr_t cap[$];

    always #5 clk = ~clk;

    async_mem_preloader u_le (
        .clk(clk), .rst_async(rst), .start(st[0]), .byte_valid(bv[0]), .byte_data(bd[0]),
        .byte_last(bl[0]), .byte_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr0),
        .mem_wdata(wd[0]), .mem_wmask(wm[0]), .busy(busy_o[0]), .done(done_o[0]),
        .overflow(ovf_o[0]),
`ifdef PRELOADER_CKSUM_EN
        .cksum(ck[0]),
`endif
        .word_count(wc0));

    async_mem_preloader #(.BIG_ENDIAN(1)) u_be (
        .clk(clk), .rst_async(rst), .start(st[1]), .byte_valid(bv[1]), .byte_data(bd[1]),
        .byte_last(bl[1]), .byte_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr1),
        .mem_wdata(wd[1]), .mem_wmask(wm[1]), .busy(busy_o[1]), .done(done_o[1]),
        .overflow(ovf_o[1]),
`ifdef PRELOADER_CKSUM_EN
        .cksum(ck[1]),
`endif
        .word_count(wc1));

    async_mem_preloader #(.ADDR_W(2), .BASE_ADDR(3)) u_ov (
        .clk(clk), .rst_async(rst), .start(st[2]), .byte_valid(bv[2]), .byte_data(bd[2]),
        .byte_last(bl[2]), .byte_ready(rdy[2]), .mem_we(we[2]), .mem_addr(addr2),
        .mem_wdata(wd[2]), .mem_wmask(wm[2]), .busy(busy_o[2]), .done(done_o[2]),
        .overflow(ovf_o[2]),
`ifdef PRELOADER_CKSUM_EN
        .cksum(ck[2]),
`endif
        .word_count(wc2));

    always_comb begin
        addr_m[0] = addr0;
        addr_m[1] = addr1;
        addr_m[2] = {10'd0, addr2};
        wc_m[0]   = wc0;
        wc_m[1]   = wc1;
        wc_m[2]   = {10'd0, wc2};
    end

    always @(negedge clk) begin
        if (we[sel]) cap.push_back('{addr: addr_m[sel], data: wd[sel], mask: wm[sel]});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic record_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or write missing", name);
    endtask

    // Reference: pack bytes into words from the spec's rules, stop at the last byte or top of memory.
    function automatic void model(input int d, input byteq_t b, output wrq_t e, output bit ovf);
        int aw   = (d == 2) ? 2 : 12;
        int addr = (d == 2) ? 3 : 0;
        bit be   = (d == 1);
        int i    = 0;
        e.delete();
        ovf = 0;
        while (i < b.size()) begin
            wr_t w;
            w.addr = addr[11:0];
            w.data = '0;
            w.mask = '0;
            for (int l = 0; l < 4 && i < b.size(); l++) begin
                int p = be ? 3 - l : l;
                w.data[p*8 +: 8] = b[i];
                w.mask[p] = 1'b1;
                i++;
            end
            e.push_back(w);
            if (i >= b.size()) break;
            if (addr == (1 << aw) - 1) begin
                ovf = 1;
                break;
            end
            addr++;
        end
    endfunction

    task automatic do_start(input int d);
        @(negedge clk);
        st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    task automatic send_bytes(input int d, input byteq_t b, input bit mark_last,
                              input int gap_max, input int mid_start);
        for (int i = 0; i < b.size(); i++) begin
            int k = 0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            if (i == mid_start) begin
                st[d] = 1'b1;
                @(negedge clk);
                st[d] = 1'b0;
            end
            bv[d] = 1'b1;
            bd[d] = b[i];
            bl[d] = mark_last && (i == b.size() - 1);
            while (!rdy[d] && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) begin
                record_fail("ready_timeout");
                bv[d] = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            bv[d] = 1'b0;
            bl[d] = 1'b0;
        end
    endtask

    task automatic run_load(input int d, input byteq_t b, input int gap_max, input int mid_start);
        wrq_t        e;
        bit          ovf;
        int          k = 0;
        logic [31:0] sum = '0;
        sel = d;
        cap.delete();
        model(d, b, e, ovf);
        foreach (b[i]) sum += {24'd0, b[i]};
        do_start(d);
        send_bytes(d, b, 1'b1, gap_max, mid_start);
        while (!done_o[d] && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("done", done_o[d], 1'b1);
        repeat (3) @(negedge clk);
        check("write_count", cap.size(), e.size());
        foreach (e[i]) begin
            if (i < cap.size()) begin
                check("wr_addr", cap[i].addr, e[i].addr);
                check("wr_data", cap[i].data, e[i].data);
                check("wr_mask", cap[i].mask, e[i].mask);
            end
        end
        check("word_count", wc_m[d], e.size());
        check("overflow", ovf_o[d], ovf);
        check("busy_in_done", busy_o[d], 1'b0);
`ifdef PRELOADER_CKSUM_EN
        check("cksum", ck[d], sum);
`endif
    endtask

    initial begin
        vec_t   vecs[4];
        byteq_t q;

        vecs[0] = '{d: 0, n: 8,  b0: 8'h01, step: 8'h01, exp_wc: 2, exp_ovf: 1'b0,
                    exp_addr: 12'd1, exp_data: 32'h08070605, exp_mask: 4'b1111};
        vecs[1] = '{d: 1, n: 4,  b0: 8'hAA, step: 8'h11, exp_wc: 1, exp_ovf: 1'b0,
                    exp_addr: 12'd0, exp_data: 32'hAABBCCDD, exp_mask: 4'b1111};
        vecs[2] = '{d: 0, n: 6,  b0: 8'h11, step: 8'h01, exp_wc: 2, exp_ovf: 1'b0,
                    exp_addr: 12'd1, exp_data: 32'h00001615, exp_mask: 4'b0011};
        vecs[3] = '{d: 2, n: 12, b0: 8'h01, step: 8'h01, exp_wc: 1, exp_ovf: 1'b1,
                    exp_addr: 12'd3, exp_data: 32'h04030201, exp_mask: 4'b1111};

        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            bv[i] = 1'b0;
            bl[i] = 1'b0;
            bd[i] = 8'h00;
        end

        repeat (3) @(negedge clk);
        check("rst_we", we[0], 1'b0);
        check("rst_ready", rdy[0], 1'b0);
        check("rst_busy", busy_o[0], 1'b0);
        check("rst_done", done_o[0], 1'b0);
        check("rst_wc", wc_m[0], 0);
        check("rst_addr_base", addr_m[2], 12'd3);
        rst = 1'b0;

        bv[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready_low", rdy[0], 1'b0);
        bv[0] = 1'b0;

        for (int v = 0; v < 4; v++) begin
            q.delete();
            for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].b0 + 8'(i) * vecs[v].step);
            run_load(vecs[v].d, q, 0, -1);
            check("tbl_wc", wc_m[vecs[v].d], vecs[v].exp_wc);
            check("tbl_ovf", ovf_o[vecs[v].d], vecs[v].exp_ovf);
            if (cap.size() == 0) begin
                record_fail("tbl_last_write");
            end else begin
                check("tbl_addr", cap[$].addr, vecs[v].exp_addr);
                check("tbl_data", cap[$].data, vecs[v].exp_data);
                check("tbl_mask", cap[$].mask, vecs[v].exp_mask);
            end
        end

        bv[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("done_ready_low", rdy[0], 1'b0);
        check("done_held", done_o[0], 1'b1);
        bv[0] = 1'b0;

        q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        run_load(0, q, 2, 2);
`ifdef PRELOADER_CKSUM_EN
        check("cksum_fixed", ck[0], 32'h000003FD);
`endif

        for (int t = 0; t < 20; t++) begin
            int d = $urandom_range(0, 2);
            int n = $urandom_range(1, (d == 2) ? 14 : 18);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            run_load(d, q, 3, $urandom_range(0, n + 3));
        end

        sel = 0;
        cap.delete();
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(8'h30 + 8'(i));
        do_start(0);
        send_bytes(0, q, 1'b0, 0, -1);
        #2 rst = 1'b1;
        #1;
        check("abort_we", we[0], 1'b0);
        check("abort_ready", rdy[0], 1'b0);
        check("abort_busy", busy_o[0], 1'b0);
        check("abort_done", done_o[0], 1'b0);
        check("abort_ovf", ovf_o[0], 1'b0);
        check("abort_addr", addr_m[0], 12'd0);
        check("abort_wc", wc_m[0], 0);
        check("abort_wdata", wd[0], 32'd0);
        check("abort_wmask", wm[0], 4'd0);
        check("abort_writes_before", cap.size(), 1);
        @(negedge clk);
        rst = 1'b0;
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(0, q, 1, -1);
        check("after_abort_data", (cap.size() > 0) ? cap[0].data : 32'd0, 32'hEFBEADDE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
